// File: rtl/axi4_lite_read_arbiter_pkg.sv
// Purpose: shared types and constants for the AXI4-Lite read arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, AXI response codes, default widths, rr pointer helper.
package axi4_lite_read_arbiter_pkg;

    localparam int DEFAULT_NUM_MASTERS   = 2;
    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int PROT_WIDTH            = 3;
    localparam int RESP_WIDTH            = 2;
    localparam int GRANT_WIDTH           = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } arb_state_e;

    typedef enum logic [RESP_WIDTH-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Index following cur, wrapping at num-1 back to 0.
    function automatic logic [GRANT_WIDTH-1:0] next_ptr(input logic [GRANT_WIDTH-1:0] cur,
                                                        input int num);
        if (int'(cur) >= num - 1) begin
            return '0;
        end
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// Purpose: round-robin pick of the first request at or after rr_ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req (request vector), rr_ptr (search start) -> gnt (one-hot), gnt_idx (binary index).
module axi4_lite_rr_arbiter
    import axi4_lite_read_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [GRANT_WIDTH-1:0] rr_ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [GRANT_WIDTH-1:0] gnt_idx
);

    logic found;

    // Two passes: first the slots at or above the pointer, then the wrapped
    // slots below it. The first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && (i >= int'(rr_ptr))) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = GRANT_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = GRANT_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Purpose: shares one AXI4-Lite read channel among NUM_MASTERS requesters, one transaction at a time.
// Latency: AR out 1 cycle after upstream handshake; R out 1 cycle after downstream R beat.
// Backpressure: upstream AR stalls while a transaction is in flight; R held until s_rready of the owner.
// Ports: s_ar*/s_r* per-master upstream slices, m_ar*/m_r* downstream, grant_id debug owner index.
module axi4_lite_read_arbiter
    import axi4_lite_read_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS   = DEFAULT_NUM_MASTERS,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = 32'hffff_ffff
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] s_araddr,
    input  logic [NUM_MASTERS*3-1:0]            s_arprot,
    input  logic [NUM_MASTERS-1:0]              s_arvalid,
    output logic [NUM_MASTERS-1:0]              s_arready,
    output logic [DATA_WIDTH-1:0]               s_rdata,
    output logic [1:0]                          s_rresp,
    output logic [NUM_MASTERS-1:0]              s_rvalid,
    input  logic [NUM_MASTERS-1:0]              s_rready,
    output logic [ADDRESS_WIDTH-1:0]            m_araddr,
    output logic [2:0]                          m_arprot,
    output logic                                m_arvalid,
    input  logic                                m_arready,
    input  logic [DATA_WIDTH-1:0]               m_rdata,
    input  logic [1:0]                          m_rresp,
    input  logic                                m_rvalid,
    output logic                                m_rready,
    output logic [1:0]                          grant_id
);

    arb_state_e                 state_q, state_d;
    logic [GRANT_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GRANT_WIDTH-1:0]     grant_id_q, grant_id_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [PROT_WIDTH-1:0]      prot_q, prot_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]      rresp_q, rresp_d;

    logic [NUM_MASTERS-1:0]     gnt;
    logic [GRANT_WIDTH-1:0]     gnt_idx;
    logic [ADDRESS_WIDTH-1:0]   sel_addr;
    logic [PROT_WIDTH-1:0]      sel_prot;
    logic [ADDRESS_WIDTH:0]     below_min;
    logic [ADDRESS_WIDTH:0]     above_max;
    logic                       addr_ok;
    logic                       rsp_phase;
    logic                       rsp_done;

    axi4_lite_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .req     (s_arvalid),
        .rr_ptr  (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Mux the winner's AR slice.
    always_comb begin
        sel_addr = '0;
        sel_prot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt[i]) begin
                sel_addr = s_araddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_prot = s_arprot[i*3 +: 3];
            end
        end
    end

    // Range check via the borrow bit of widened subtractions, which stays
    // well-formed even when a bound sits at the edge of the address space.
    assign below_min = {1'b0, sel_addr} - {1'b0, MIN_ADDRESS};
    assign above_max = {1'b0, MAX_ADDRESS} - {1'b0, sel_addr};
    assign addr_ok   = !below_min[ADDRESS_WIDTH] && !above_max[ADDRESS_WIDTH];

    assign rsp_phase = (state_q == ST_RESP) || (state_q == ST_ERR);

    always_comb begin
        s_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_rvalid[i] = rsp_phase && (grant_id_q == GRANT_WIDTH'(i));
        end
    end

    // s_rvalid is one-hot on the owner, so this is the owner's R handshake.
    assign rsp_done = |(s_rvalid & s_rready);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        addr_d     = addr_q;
        prot_d     = prot_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    grant_id_d = gnt_idx;
                    addr_d     = sel_addr;
                    prot_d     = sel_prot;
                    if (addr_ok) begin
                        state_d = ST_ADDR;
                    end else begin
                        // Decode error is answered locally with zero data.
                        state_d = ST_ERR;
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    rresp_d = m_rresp;
                    state_d = ST_RESP;
                end
            end
            ST_RESP, ST_ERR: begin
                if (rsp_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr(grant_id_q, NUM_MASTERS);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            addr_q     <= '0;
            prot_q     <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            addr_q     <= addr_d;
            prot_q     <= prot_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Only the IDLE grant is combinational; everything else decodes flops.
    assign s_arready = (state_q == ST_IDLE) ? gnt : '0;
    assign m_arvalid = (state_q == ST_ADDR);
    assign m_rready  = (state_q == ST_DATA);
    assign m_araddr  = addr_q;
    assign m_arprot  = prot_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Purpose: directed self-checking bench for axi4_lite_read_arbiter with a transaction-level model.
// Latency: n/a.
// Backpressure: bench-driven m_arready/m_rvalid delays and s_rready holds.
module tb_axi4_lite_read_arbiter;

    localparam int          N    = 2;
    localparam logic [31:0] MAXA = 32'h0000_FFFF;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] s_araddr;
    logic [5:0]  s_arprot;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [1:0]  grant_id;

    axi4_lite_read_arbiter #(
        .NUM_MASTERS   (N),
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MIN_ADDRESS   (32'h0000_0000),
        .MAX_ADDRESS   (MAXA)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_araddr  (s_araddr),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .grant_id  (grant_id)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus configuration ----------------
    logic [31:0] cfg_rdata = 32'h0;
    logic [1:0]  cfg_rresp = 2'b00;
    int          cfg_ar_delay = 0;
    int          cfg_r_delay  = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    // ---------------- observation logs ----------------
    int          cyc = 0;
    int          hs_cyc = 0;
    int          rise_lat = -1;
    int          arv_cycles = 0;
    int          rvalid_cycles = 0;
    logic        arv_prev = 1'b0;
    logic [1:0]  hs_n = 2'b00;
    int          grant_log[$];
    int          resp_idx[$];
    int          resp_gid[$];
    logic [31:0] resp_data[$];
    logic [1:0]  resp_resp[$];

    always @(negedge aclk) begin
        cyc++;
        hs_n = aresetn ? (s_arvalid & s_arready) : 2'b00;
        if (hs_n != 2'b00) begin
            grant_log.push_back(hs_n[1] ? 1 : 0);
            hs_cyc = cyc;
        end
        if (m_arvalid === 1'b1) begin
            arv_cycles++;
            if (!arv_prev) rise_lat = cyc - hs_cyc;
        end
        arv_prev = (m_arvalid === 1'b1);
        if (s_rvalid != 2'b00) rvalid_cycles++;
        if (aresetn && ((s_rvalid & s_rready) != 2'b00)) begin
            resp_idx.push_back(s_rvalid[1] ? 1 : 0);
            resp_gid.push_back(int'(grant_id));
            resp_data.push_back(s_rdata);
            resp_resp.push_back(s_rresp);
        end
    end

    // Upstream masters: each holds s_arvalid until its handshake, then loads the next queued address.
    always @(posedge aclk) begin
        #1;
        if (hs_n[0]) s_arvalid[0] = 1'b0;
        if (hs_n[1]) s_arvalid[1] = 1'b0;
        if (!s_arvalid[0] && q0.size() > 0) begin
            s_araddr[31:0] = q0.pop_front();
            s_arvalid[0]   = 1'b1;
        end
        if (!s_arvalid[1] && q1.size() > 0) begin
            s_araddr[63:32] = q1.pop_front();
            s_arvalid[1]    = 1'b1;
        end
    end

    // Downstream slave with configurable AR and R delays.
    int ar_wait = 0;
    int r_wait  = 0;
    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            ar_wait   = 0;
            r_wait    = 0;
        end else begin
            if (m_arready) begin
                m_arready = 1'b0;
            end else if (m_arvalid) begin
                if (ar_wait >= cfg_ar_delay) begin
                    m_arready = 1'b1;
                    ar_wait   = 0;
                end else begin
                    ar_wait++;
                end
            end
            if (m_rvalid) begin
                m_rvalid = 1'b0;
            end else if (m_rready) begin
                if (r_wait >= cfg_r_delay) begin
                    m_rvalid = 1'b1;
                    m_rdata  = cfg_rdata;
                    m_rresp  = cfg_rresp;
                    r_wait   = 0;
                end else begin
                    r_wait++;
                end
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // owner < 0: channel free. phase: 1 = address out, 2 = awaiting data, 3 = replying upstream.
    int          mo_owner = -1;
    int          mo_phase = 0;
    int          mo_ptr = 0;
    int          mo_gid = 0;
    int          mo_win = 0;
    logic [31:0] mo_addr = 32'h0;
    logic [31:0] mo_rdata = 32'h0;
    logic [1:0]  mo_rresp = 2'b00;
    logic        mo_valid = 1'b0;

    function automatic int pick(input logic [1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            mo_owner = -1; mo_phase = 0; mo_ptr = 0; mo_gid = 0;
            mo_addr = 32'h0; mo_rdata = 32'h0; mo_rresp = 2'b00;
            mo_valid = 1'b1;
        end else if (mo_owner < 0) begin
            mo_win = pick(s_arvalid, mo_ptr);
            if (mo_win >= 0) begin
                mo_owner = mo_win;
                mo_gid   = mo_win;
                mo_addr  = s_araddr[mo_win*32 +: 32];
                if (mo_addr <= MAXA) begin
                    mo_phase = 1;
                end else begin
                    mo_phase = 3;
                    mo_rdata = 32'h0;
                    mo_rresp = 2'b11;
                end
            end
        end else if (mo_phase == 1) begin
            if (m_arready) mo_phase = 2;
        end else if (mo_phase == 2) begin
            if (m_rvalid) begin
                mo_rdata = m_rdata;
                mo_rresp = m_rresp;
                mo_phase = 3;
            end
        end else if (s_rready[mo_owner]) begin
            mo_ptr   = (mo_owner + 1) % N;
            mo_owner = -1;
        end
    end

    // Per-cycle comparison against the model.
    logic [1:0] exp_ar;
    logic [1:0] exp_rv;
    int         exp_pick;
    always @(negedge aclk) begin
        if (mo_valid) begin
            exp_pick = pick(s_arvalid, mo_ptr);
            exp_ar = (mo_owner < 0 && exp_pick >= 0) ? 2'(1 << exp_pick) : 2'b00;
            exp_rv = (mo_owner >= 0 && mo_phase == 3) ? 2'(1 << mo_owner) : 2'b00;
            chk("s_arready", s_arready, exp_ar);
            chk("m_arvalid", m_arvalid, (mo_owner >= 0 && mo_phase == 1));
            chk("m_rready", m_rready, (mo_owner >= 0 && mo_phase == 2));
            chk("s_rvalid", s_rvalid, exp_rv);
            chk("grant_id", grant_id, mo_gid);
            if (mo_owner >= 0 && mo_phase == 1) chk("m_araddr", m_araddr, mo_addr);
            if (exp_rv != 2'b00) begin
                chk("s_rdata", s_rdata, mo_rdata);
                chk("s_rresp", s_rresp, mo_rresp);
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_resp(input int n);
        for (int i = 0; i < 200 && resp_data.size() < n; i++) step(1);
        chk("resp_count", resp_data.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_arvalid"}, m_arvalid, 0);
        chk({tag, "_m_rready"}, m_rready, 0);
        chk({tag, "_s_rvalid"}, s_rvalid, 0);
        chk({tag, "_s_rdata"}, s_rdata, 0);
        chk({tag, "_s_rresp"}, s_rresp, 0);
        chk({tag, "_m_araddr"}, m_araddr, 0);
        chk({tag, "_m_arprot"}, m_arprot, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    int b;
    int k;
    initial begin
        aresetn = 1'b0; s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = 2'b11;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
        step(2);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        step(1);

        // Single master 0 read, OKAY data.
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
        q0.push_back(32'h0000_1000);
        wait_resp(1);
        chk("t1_master", resp_idx[0], 0);
        chk("t1_rdata", resp_data[0], 32'hDEAD_BEEF);
        chk("t1_rresp", resp_resp[0], 2'b00);
        chk("t1_arvalid_latency", rise_lat, 1);

        // Simultaneous requests from reset alternate 0,1,0,1.
        aresetn = 1'b0; step(1); aresetn = 1'b1;
        b = resp_data.size();
        k = grant_log.size();
        cfg_rdata = 32'h0BAD_F00D;
        q0.push_back(32'h100); q0.push_back(32'h104);
        q1.push_back(32'h200); q1.push_back(32'h204);
        wait_resp(b + 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant_order", grant_log[k + i], i % 2);
            chk("t2_resp_master", resp_idx[b + i], i % 2);
            chk("t2_resp_grant_id", resp_gid[b + i], i % 2);
        end

        // Out-of-range request from master 1 gets a local DECERR.
        b = resp_data.size();
        k = arv_cycles;
        q1.push_back(32'h0001_0000);
        wait_resp(b + 1);
        chk("t3_no_arvalid", arv_cycles, k);
        chk("t3_master", resp_idx[b], 1);
        chk("t3_rdata", resp_data[b], 32'h0);
        chk("t3_rresp", resp_resp[b], 2'b11);

        // Hold s_rready[0] low 5 cycles; master 1 waits, then is granted right after the handshake.
        cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b01;
        s_rready[0] = 1'b0;
        q0.push_back(32'h0000_2000);
        for (int i = 0; i < 50 && s_rvalid[0] !== 1'b1; i++) step(1);
        q1.push_back(32'h0000_3000);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_rvalid", s_rvalid, 2'b01);
            chk("t4_hold_rdata", s_rdata, 32'h1234_5678);
            chk("t4_hold_rresp", s_rresp, 2'b01);
            step(1);
        end
        b = resp_data.size();
        s_rready[0] = 1'b1;
        step(1);
        chk("t4_regrant_master1", s_arready, 2'b10);
        wait_resp(b + 2);
        chk("t4_second_master", resp_idx[b + 1], 1);

        // SLVERR forwarded unmodified.
        b = resp_data.size();
        cfg_rdata = 32'hCAFE_0001; cfg_rresp = 2'b10;
        q0.push_back(32'h0000_0010);
        wait_resp(b + 1);
        chk("t5_rresp", resp_resp[b], 2'b10);
        chk("t5_rdata", resp_data[b], 32'hCAFE_0001);

        // Slow AR acceptance, then reset while waiting for data: transaction is dropped.
        cfg_ar_delay = 3; cfg_r_delay = 5; cfg_rresp = 2'b00;
        q1.push_back(32'h0000_4000);
        for (int i = 0; i < 50 && m_rready !== 1'b1; i++) step(1);
        chk("t6_reached_data", m_rready, 1);
        aresetn = 1'b0;
        step(1);
        check_reset_outputs("t6_reset");
        aresetn = 1'b1;
        b = resp_data.size();
        k = rvalid_cycles;
        step(30);
        chk("t6_no_rvalid_after", rvalid_cycles, k);
        chk("t6_no_resp_after", resp_data.size(), b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
